// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared defaults, FSM encoding and per-thread register map for the write arbiter.
package regfile_wr_arbiter_pkg;

  localparam int unsigned DEF_DATAPATH_WIDTH     = 64;
  localparam int unsigned DEF_REGFILE_ADDR_WIDTH = 5;
  localparam int unsigned DEF_NUM_ACTIONS        = 8;
  localparam int unsigned DEF_THREAD_BITS        = 2;
  localparam int unsigned DEF_FIFO_DEPTH         = 4;

  // Each thread owns a bank of eight registers; actions touch the top two.
  localparam int unsigned REGS_PER_THREAD = 8;
  localparam int unsigned DATA_REG_OFFSET = 7;
  localparam int unsigned MASK_REG_OFFSET = 6;

  // IDLE: head action not started; MASK: head DATA written, MASK still owed.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MASK = 1'b1
  } arb_state_e;

  // Register index of a given offset within a thread's bank.
  function automatic int unsigned thread_reg_index(input int unsigned thread,
                                                   input int unsigned offset);
    return thread * REGS_PER_THREAD + offset;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_action_fifo.sv
// Synchronous action queue with full/empty/count; depth must be a power of two.
module action_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == CNT_WIDTH'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writebacks (priority) and queued
// actions, each action expanding into a DATA write followed by a MASK write.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATAPATH_WIDTH     = DEF_DATAPATH_WIDTH,
  parameter int unsigned REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
  parameter int unsigned NUM_ACTIONS        = DEF_NUM_ACTIONS,
  parameter int unsigned THREAD_BITS        = DEF_THREAD_BITS,
  parameter int unsigned FIFO_DEPTH         = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_wen,
  input  logic [REGFILE_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATAPATH_WIDTH-1:0]     wb_data,
  input  logic                          act_valid,
  output logic                          act_ready,
  input  logic [NUM_ACTIONS-1:0]        act_data,
  input  logic [THREAD_BITS-1:0]        act_thread,
  output logic                          rf_wena,
  output logic [REGFILE_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATAPATH_WIDTH-1:0]     rf_wr_data,
  output logic                          act_done,
  output logic [THREAD_BITS-1:0]        act_done_thread,
  output logic                          busy
);

  localparam int unsigned ENTRY_WIDTH = THREAD_BITS + NUM_ACTIONS;
  localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LOW_WIDTH   = DATAPATH_WIDTH - NUM_ACTIONS;
  localparam logic [DATAPATH_WIDTH-1:0] MASK_WORD = {{NUM_ACTIONS{1'b0}}, {LOW_WIDTH{1'b1}}};

  arb_state_e                    state;
  arb_state_e                    state_nxt;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [COUNT_WIDTH-1:0]        fifo_count;
  logic [ENTRY_WIDTH-1:0]        fifo_head;
  logic                          fifo_pop;
  logic [THREAD_BITS-1:0]        head_thread;
  logic [NUM_ACTIONS-1:0]        head_actions;
  logic                          wena_nxt;
  logic [REGFILE_ADDR_WIDTH-1:0] addr_nxt;
  logic [DATAPATH_WIDTH-1:0]     data_nxt;
  logic                          done_nxt;
  logic [THREAD_BITS-1:0]        done_thread_nxt;

  assign act_ready    = !fifo_full;
  assign head_thread  = fifo_head[ENTRY_WIDTH-1 -: THREAD_BITS];
  assign head_actions = fifo_head[NUM_ACTIONS-1:0];
  assign busy         = (fifo_count != '0) || (state != ST_IDLE);

  action_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_action_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (act_valid && act_ready),
    .push_data ({act_thread, act_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Per-cycle arbitration: writeback first, then head DATA, then head MASK.
  always_comb begin
    state_nxt       = state;
    wena_nxt        = 1'b0;
    addr_nxt        = rf_wr_addr;
    data_nxt        = rf_wr_data;
    done_nxt        = 1'b0;
    done_thread_nxt = act_done_thread;
    fifo_pop        = 1'b0;
    if (wb_wen) begin
      wena_nxt = 1'b1;
      addr_nxt = wb_addr;
      data_nxt = wb_data;
    end else if (state == ST_IDLE && !fifo_empty) begin
      wena_nxt  = 1'b1;
      addr_nxt  = REGFILE_ADDR_WIDTH'(thread_reg_index(32'(head_thread), DATA_REG_OFFSET));
      data_nxt  = {head_actions, {LOW_WIDTH{1'b0}}};
      state_nxt = ST_MASK;
    end else if (state == ST_MASK) begin
      wena_nxt        = 1'b1;
      addr_nxt        = REGFILE_ADDR_WIDTH'(thread_reg_index(32'(head_thread), MASK_REG_OFFSET));
      data_nxt        = MASK_WORD;
      done_nxt        = 1'b1;
      done_thread_nxt = head_thread;
      fifo_pop        = 1'b1;
      state_nxt       = ST_IDLE;
    end
  end

  // FSM state and registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      rf_wena         <= 1'b0;
      rf_wr_addr      <= '0;
      rf_wr_data      <= '0;
      act_done        <= 1'b0;
      act_done_thread <= '0;
    end else begin
      state           <= state_nxt;
      rf_wena         <= wena_nxt;
      rf_wr_addr      <= addr_nxt;
      rf_wr_data      <= data_nxt;
      act_done        <= done_nxt;
      act_done_thread <= done_thread_nxt;
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock and reset are named clk and reset as elsewhere in the codebase.
REQ-002 Parameters SHALL be: DATAPATH_WIDTH, 64, register data width; REGFILE_ADDR_WIDTH, 5, register address width; NUM_ACTIONS, 8, action field width; THREAD_BITS, 2, thread-id width; FIFO_DEPTH, 4, action queue depth (power of two, at least 2).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 wb_wen  in  1  writeback write request; never stalled.
REQ-006 wb_addr  in  REGFILE_ADDR_WIDTH  writeback register index.
REQ-007 wb_data  in  DATAPATH_WIDTH  writeback data.
REQ-008 act_valid  in  1  action request valid.
REQ-009 act_ready  out  1  action request accepted at this edge if act_valid is high.
REQ-010 act_data  in  NUM_ACTIONS  action bitfield.
REQ-011 act_thread  in  THREAD_BITS  target thread.
REQ-012 rf_wena  out  1  register-file write enable, registered.
REQ-013 rf_wr_addr  out  REGFILE_ADDR_WIDTH  register-file write address, registered.
REQ-014 rf_wr_data  out  DATAPATH_WIDTH  register-file write data, registered.
REQ-015 act_done  out  1  one-cycle pulse when an action's final write is driven.
REQ-016 act_done_thread  out  THREAD_BITS  thread of the completing action; valid only with act_done.
REQ-017 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-018 act_ready SHALL equal NOT fifo_full; an accepted request is pushed into the FIFO as {act_thread, act_data}.
REQ-019 Each action SHALL produce two register writes: DATA to index t*8+7 with value act_data in bits [DATAPATH_WIDTH-1 -: NUM_ACTIONS] and zeros elsewhere, then MASK to index t*8+6 with value zeros in the top NUM_ACTIONS bits and ones elsewhere (0x00FF_FFFF_FFFF_FFFF at defaults).
REQ-020 The FSM SHALL have two states: IDLE (head not started) and MASK (head DATA written, MASK pending).
REQ-021 Arbitration per cycle SHALL be: wb_wen high -> the next-cycle rf_* carries the writeback and the FSM holds; otherwise IDLE with FIFO non-empty -> issue DATA and go to MASK; otherwise in MASK -> issue MASK, pop the FIFO, pulse act_done for that cycle, go to IDLE; otherwise rf_wena=0.
REQ-022 Latency SHALL be: writeback at edge E appears on rf_* in the cycle after E; an action accepted at edge E0 with no writeback contention drives DATA after E0+1 and MASK plus act_done after E0+2.
REQ-023 Actions SHALL complete in acceptance order; DATA and MASK of one action SHALL never interleave with another action's writes, though writebacks may separate them.
REQ-024 Continuous wb_wen MAY starve actions indefinitely; the FIFO then fills and act_ready deasserts, with no request lost or duplicated.
REQ-025 Push and pop in the same cycle SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 A writeback to t*8+7 or t*8+6 SHALL NOT be suppressed; the last write issued wins.

Reset
REQ-027 While reset is low: rf_wena=0, rf_wr_addr=0, rf_wr_data=0, act_done=0, act_done_thread=0, FIFO empty, act_ready=1, busy=0, FSM=IDLE.
REQ-028 Reset asserted mid-action SHALL discard the in-flight action and all queued actions with no act_done; the first edge after release behaves as from an empty queue.

Structure
REQ-029 A shared package SHALL hold the parameter defaults, the FSM state encoding, the DATA/MASK register offsets (7, 6) and a function mapping a thread to its register index.
REQ-030 The FIFO SHALL be a sub-module named action_fifo (synchronous, full/empty/count, async active-low reset).

Verification
REQ-031 Single action with act_thread=1, act_data=0xA5, no writeback -> DATA: rf_wr_addr=15, data 0xA500_0000_0000_0000; next cycle MASK: addr 14, data 0x00FF_FFFF_FFFF_FFFF, act_done=1, act_done_thread=1.
REQ-032 wb_wen with addr 3 and data 0x1234 in the cycle between an action's DATA and MASK -> writes issue in order DATA(7), wb(3), MASK(6) for thread 0.
REQ-033 wb_wen held for 10 cycles while 5 actions are offered -> 4 accepted, act_ready=0 on the 5th until the first pop; then all 5 complete in order.
REQ-034 act_thread=3, act_data=0xFF -> writes to addr 31 (0xFF00_0000_0000_0000) then addr 30.
REQ-035 reset pulled low during MASK with 2 actions queued -> outputs zero immediately, no act_done, busy=0 after release.
